// File: rtl/vga_pkg.sv
// Shared screen geometry and pixel types for the drawing pipeline.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] colour_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    colour_t    colour;
  } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO holding accepted, on-screen pixels for the VGA adapter.
// Pointers wrap modulo DEPTH (power of 2); occupancy is one bit wider than the pointers.
module plot_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         elem_t = pixel_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  elem_t wdata,
  input  logic  pop,
  output elem_t rdata,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  elem_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_clip_buffer.sv
// Clips drawer pixels to the visible screen, buffers survivors and feeds vga_adapter.
// Optional macro PIXEL_CLIP_STATS_EN enables the dropped-pixel counter on clip_count;
// without it clip_count is tied to zero.
module pixel_clip_buffer
  import vga_pkg::*;
#(
  parameter int          SCREEN_W = vga_pkg::SCREEN_W,
  parameter int          SCREEN_H = vga_pkg::SCREEN_H,
  parameter int          COORD_W  = 9,
  parameter int unsigned DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [2:0]         in_colour,
  input  logic               in_last,
  input  logic               out_ready,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic               done,
  output logic [15:0]        clip_count
);

  localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
  localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

  logic   full;
  logic   empty;
  logic   accept;
  logic   in_range;
  logic   push;
  logic   pop;
  logic   last_pending;
  pixel_t wr_pixel;
  pixel_t head;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign pop      = out_ready && !empty;

  // Sign bit catches negatives; the signed compare catches the far edges.
  assign in_range = !in_x[COORD_W-1] && ($signed(in_x) < X_LIM) &&
                    !in_y[COORD_W-1] && ($signed(in_y) < Y_LIM);
  assign push     = accept && in_range;

  assign wr_pixel = '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};

  plot_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (pixel_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_pixel),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Registered adapter interface: a plot strobe per popped pixel, coordinates held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (pop) begin
      vga_x      <= head.x;
      vga_y      <= head.y;
      vga_colour <= head.colour;
      vga_plot   <= 1'b1;
    end else begin
      vga_plot   <= 1'b0;
    end
  end

  // Completion tracking: done rises once the last beat has been accepted and everything drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done         <= 1'b0;
      last_pending <= 1'b0;
    end else if (accept) begin
      done <= 1'b0;
      if (in_last) last_pending <= 1'b1;
    end else if (last_pending && empty && !pop) begin
      done         <= 1'b1;
      last_pending <= 1'b0;
    end
  end

`ifdef PIXEL_CLIP_STATS_EN
  // Saturating count of beats dropped by the clip test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_count <= '0;
    end else if (accept && !in_range && (clip_count != '1)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_pixel_clip_buffer.sv
// Scoreboard bench for pixel_clip_buffer: a queue-level reference model predicts accepts,
// clips, plot timing and done; a negedge monitor checks DUT outputs against it.
module tb_pixel_clip_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_x = '0;
  logic [8:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;
  logic [15:0] clip_count;

  pixel_clip_buffer #(
    .SCREEN_W (160),
    .SCREEN_H (120),
    .COORD_W  (9),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_last    (in_last),
    .out_ready  (out_ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (done),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  px_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int occ      = 0;
  int exp_plot = 0;
  int exp_done = 0;
  int lp       = 0;
  int exp_clip = 0;
  int m_acc    = 0;
  int m_xi, m_yi, m_pop, m_inr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip_expect();
`ifdef PIXEL_CLIP_STATS_EN
    return exp_clip;
`else
    return 0;
`endif
  endfunction

  // Reference model: screen-rule clipping, an occupancy count and an ordered queue of survivors.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      occ = 0; exp_plot = 0; exp_done = 0; lp = 0; exp_clip = 0; m_acc = 0;
      sb_q.delete();
    end else begin
      m_xi  = int'($signed(in_x));
      m_yi  = int'($signed(in_y));
      m_inr = (m_xi >= 0 && m_xi < 160 && m_yi >= 0 && m_yi < 120) ? 1 : 0;
      m_acc = (in_valid && occ < DEPTH) ? 1 : 0;
      m_pop = (out_ready && occ > 0) ? 1 : 0;
      if (m_acc != 0) begin
        exp_done = 0;
        if (in_last) lp = 1;
      end else if (lp != 0 && occ == 0) begin
        exp_done = 1;
        lp = 0;
      end
      if (m_acc != 0) begin
        if (m_inr != 0) begin
          sb_q.push_back('{x: m_xi, y: m_yi, c: int'(in_colour)});
          occ++;
        end else if (exp_clip < 65535) begin
          exp_clip++;
        end
      end
      if (m_pop != 0) occ--;
      exp_plot = m_pop;
    end
  end

  // Monitor: compare outputs each negedge; plotted pixels are popped from the scoreboard.
  int hx = 0, hy = 0, hc = 0;
  px_t got;
  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) begin
      hx = 0; hy = 0; hc = 0;
    end else begin
      chk("vga_plot", int'(vga_plot), exp_plot);
      chk("in_ready", int'(in_ready), (occ < DEPTH) ? 1 : 0);
      chk("done", int'(done), exp_done);
      chk("clip_count", int'(clip_count), clip_expect());
      if (vga_plot) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_plot: got (%0d,%0d) expected no plot at %0t",
                   vga_x, vga_y, $time);
        end else begin
          got = sb_q.pop_front();
          chk("plot_x", int'(vga_x), got.x);
          chk("plot_y", int'(vga_y), got.y);
          chk("plot_colour", int'(vga_colour), got.c);
          hx = got.x; hy = got.y; hc = got.c;
        end
      end else begin
        chk("hold_x", int'(vga_x), hx);
        chk("hold_y", int'(vga_y), hy);
        chk("hold_colour", int'(vga_colour), hc);
      end
    end
  end

  task automatic drive(input int x, input int y, input int c, input bit last);
    int xv, yv, cv;
    xv = x; yv = y; cv = c;
    in_valid  = 1'b1;
    in_x      = xv[8:0];
    in_y      = yv[8:0];
    in_colour = cv[2:0];
    in_last   = last;
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (m_acc == 0 && n < 50);
    if (m_acc == 0) chk({name, "_accept_timeout"}, 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic beat(input int x, input int y, input int c, input bit last);
    drive(x, y, c, last);
    wait_accept("beat");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_clip", int'(clip_count), 0);
    chk("rst_ready", int'(in_ready), 1);
    rst = 1'b0;
    idle(2);

    // single pixel latency and hold
    out_ready = 1'b1;
    beat(79, 61, 2, 0);
    idle(4);
    chk("held_x_79", int'(vga_x), 79);
    chk("held_y_61", int'(vga_y), 61);

    // clipping
    beat(-1, 10, 1, 0);
    beat(160, 5, 1, 0);
    beat(10, 120, 1, 0);
    beat(0, 0, 5, 0);
    idle(4);
`ifdef PIXEL_CLIP_STATS_EN
    chk("clip_total", int'(clip_count), 3);
`else
    chk("clip_total", int'(clip_count), 0);
`endif

    // backpressure: fill, stall fifth beat, then drain
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) beat(i, i, i, 0);
    drive(5, 5, 5, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("full_ready", int'(in_ready), 0);
      chk("full_noplot", int'(vga_plot), 0);
    end
    out_ready = 1'b1;
    wait_accept("fifth");
    idle(8);

    // done on clipped last beat
    beat(5, 5, 3, 0);
    beat(200, 200, 4, 1);
    idle(3);
    chk("done_high", int'(done), 1);
    idle(2);
    chk("done_hold", int'(done), 1);
    beat(1, 2, 6, 0);
    chk("done_cleared", int'(done), 0);
    idle(3);

    // asynchronous reset with pixels buffered
    out_ready = 1'b0;
    beat(10, 10, 1, 0);
    beat(20, 20, 2, 0);
    beat(30, 30, 3, 0);
    out_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_plot", int'(vga_plot), 0);
    chk("async_x", int'(vga_x), 0);
    chk("async_y", int'(vga_y), 0);
    chk("async_colour", int'(vga_colour), 0);
    chk("async_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);

    // screen boundaries
    beat(159, 119, 7, 0);
    beat(160, 119, 7, 0);
    beat(159, 120, 7, 0);
    beat(0, 0, 1, 0);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        drive(int'($urandom_range(0, 220)) - 20, int'($urandom_range(0, 170)) - 20,
              int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
      else
        in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(10);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
